rssi_cca_fsm: RTL
=================

# rssi_cca_fsm

Consumer end of the RSSI stream: takes the per-sample `rssi_half_db` / `rssi_half_db_valid` pair from the RSSI block and turns it into a debounced clear-channel-assessment (CCA) decision for the xpu. Applies threshold, hysteresis and an assert count, plus a hold-off timer, and treats local transmission as busy. Also accumulates channel-busy time and reports the peak RSSI of each busy episode.

## Interface
- `RSSI_HALF_DB_WIDTH`, 11, width of signed RSSI values, 0.5 dB/LSB
- `CNT_WIDTH`, 8, width of the assert-count setting
- `HOLD_WIDTH`, 16, width of the hold-off cycle setting
- `BUSY_TIME_WIDTH`, 32, width of the busy-time accumulator

- `clk`  in  1  single clock; all logic on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `rssi_half_db`  in  RSSI_HALF_DB_WIDTH  signed RSSI sample
- `rssi_half_db_valid`  in  1  sample strobe, one cycle per sample
- `tx_on`  in  1  local transmitter active (level)
- `busy_th`  in  RSSI_HALF_DB_WIDTH  signed busy threshold
- `hyst`  in  4  unsigned hysteresis, 0.5 dB/LSB
- `assert_cnt`  in  CNT_WIDTH  consecutive above-threshold samples required; 0 behaves as 1
- `hold_cycles`  in  HOLD_WIDTH  clk cycles of below-threshold before idle
- `busy_time_clr`  in  1  synchronous clear of `busy_time`
- `ch_idle`  out  1  registered CCA result; 1 = idle
- `ch_busy_rise`  out  1  one-cycle strobe on entry to BUSY from IDLE/PEND
- `ch_idle_rise`  out  1  one-cycle strobe on HOLD→IDLE
- `busy_time`  out  BUSY_TIME_WIDTH  saturating count of cycles with `ch_idle`=0
- `rssi_peak_half_db`  out  RSSI_HALF_DB_WIDTH  signed peak of the last completed episode
- `state`  out  2  current state: IDLE=0, PEND=1, BUSY=2, HOLD=3

## Operation
- Per valid sample: `above` = rssi ≥ busy_th. `below` = rssi < busy_th − hyst. Compute the subtraction sign-extended to RSSI_HALF_DB_WIDTH+1 bits, so there is no wrap near the negative limit. A sample that is neither above nor below is neutral.
- IDLE: an above sample with eff_cnt=1 → BUSY. An above sample with eff_cnt>1 → PEND, run counter=1.
- PEND: an above sample increments the run counter. When the counter reaches eff_cnt → BUSY. A below or neutral sample → IDLE, counter cleared.
- BUSY: a below sample → HOLD and loads the hold counter with `hold_cycles`. Neutral and above samples stay in BUSY.
- HOLD: the counter decrements every clk. At 0 → IDLE. An above sample → BUSY, counter discarded. `hold_cycles`=0 gives HOLD for exactly one cycle.
- `tx_on`=1 forces BUSY from any state and overrides sample events in the same cycle. In BUSY with `tx_on`=1, below samples are ignored. On the `tx_on` fall the block enters HOLD.
- `ch_idle` = 1 in IDLE and PEND, 0 in BUSY and HOLD. `ch_busy_rise` fires only on the IDLE/PEND→BUSY edge, not on HOLD→BUSY.
- Episode peak register:
  - Loaded on entry to BUSY from IDLE/PEND: with the triggering sample, or with the most negative value when entry is via `tx_on`.
  - Updated with max(peak, sample) on every valid sample in BUSY/HOLD.
  - Copied to `rssi_peak_half_db` on HOLD→IDLE.
- `busy_time` increments every cycle with `ch_idle`=0 and saturates at all-ones. `busy_time_clr` has priority over increment; the result is 0 that cycle.
- `busy_th`, `hyst`, `assert_cnt`, `hold_cycles` are sampled live. A change mid-episode affects only subsequent decisions.

## Timing
- All outputs are registered. The state, `ch_idle` and strobes update on the clk edge after the valid sample (or `tx_on` change) that causes the transition. Latency is 1 cycle.
- HOLD lasts `hold_cycles`+1 cycles when no above sample arrives. `ch_idle` rises on the cycle after the counter reads 0.
- Reset values: state=IDLE, `ch_idle`=1, both strobes=0, `busy_time`=0, `rssi_peak_half_db`=most negative value (−1024 at default width), all counters 0.
- An asserted `rst` mid-episode returns the block to IDLE immediately (asynchronous). No `ch_idle_rise` is produced and the peak is not published.
- `busy_time` counts the cycle in which `ch_idle` is 0 at register output.

## Test plan
- busy_th=−100, hyst=4, assert_cnt=3, hold_cycles=10. Drive samples −90,−90,−90 at 1 per 4 clk → PEND, PEND, then BUSY one cycle after the third valid; single `ch_busy_rise`.
- From BUSY, drive sample −102 (neutral), then −110 (below) → stays BUSY on −102; HOLD after −110. `ch_idle` rises exactly 11 cycles after HOLD entry, with a one-cycle `ch_idle_rise`. `rssi_peak_half_db`=−90.
- In HOLD at count 5, drive sample −95 → BUSY next cycle, no `ch_busy_rise`. The peak continues tracking.
- In IDLE, assert `tx_on` for 20 cycles alongside below samples → BUSY 1 cycle later, HOLD when tx falls, IDLE after `hold_cycles`+1. `busy_time` increases by the exact busy-cycle count.
- assert_cnt=0, busy_th=−1024, sample −1024 → BUSY directly from IDLE. The threshold-minus-hyst computation does not wrap, so no false below decision.
- Preload `busy_time` near saturation by a long tx_on → holds all-ones. `busy_time_clr` pulsed while busy → 0 that cycle, 1 the next. An async `rst` mid-BUSY → IDLE immediately.

Source files
------------

// File: rtl/rssi_cca_fsm.sv
// Debounced clear-channel assessment from the per-sample RSSI stream, with hold-off timer,
// busy-time accumulator and per-episode peak RSSI capture.
module rssi_cca_fsm #(
  parameter int unsigned RSSI_HALF_DB_WIDTH = 11,
  parameter int unsigned CNT_WIDTH          = 8,
  parameter int unsigned HOLD_WIDTH         = 16,
  parameter int unsigned BUSY_TIME_WIDTH    = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic signed [RSSI_HALF_DB_WIDTH-1:0] rssi_half_db,
  input  logic                                 rssi_half_db_valid,
  input  logic                                 tx_on,
  input  logic signed [RSSI_HALF_DB_WIDTH-1:0] busy_th,
  input  logic [3:0]                           hyst,
  input  logic [CNT_WIDTH-1:0]                 assert_cnt,
  input  logic [HOLD_WIDTH-1:0]                hold_cycles,
  input  logic                                 busy_time_clr,
  output logic                                 ch_idle,
  output logic                                 ch_busy_rise,
  output logic                                 ch_idle_rise,
  output logic [BUSY_TIME_WIDTH-1:0]           busy_time,
  output logic signed [RSSI_HALF_DB_WIDTH-1:0] rssi_peak_half_db,
  output logic [1:0]                           state
);

  localparam int unsigned W = RSSI_HALF_DB_WIDTH;
  localparam logic signed [W-1:0]         RssiMin = {1'b1, {(W-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0]        CntOne  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH:0]          RunOne  = {{CNT_WIDTH{1'b0}}, 1'b1};
  localparam logic [HOLD_WIDTH-1:0]       HoldOne = {{(HOLD_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [BUSY_TIME_WIDTH-1:0]  BtOne   = {{(BUSY_TIME_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPend = 2'd1,
    StBusy = 2'd2,
    StHold = 2'd3
  } state_e;

  state_e                      state_q, state_d;
  logic [CNT_WIDTH-1:0]        run_q, run_d;
  logic [HOLD_WIDTH-1:0]       hold_q, hold_d;
  logic signed [W-1:0]         peak_q, peak_d;
  logic signed [W-1:0]         pub_q, pub_d;
  logic [BUSY_TIME_WIDTH-1:0]  bt_q, bt_d;
  logic                        idle_q, idle_d;
  logic                        brise_q, brise_d;
  logic                        irise_q, irise_d;
  logic                        tx_q;

  logic [CNT_WIDTH-1:0] eff_cnt;
  logic [CNT_WIDTH:0]   run_inc;
  logic signed [W:0]    lo_th;
  logic signed [W:0]    rssi_ext;
  logic signed [W-1:0]  peak_max;
  logic                 above, below;

  assign eff_cnt  = (assert_cnt == '0) ? CntOne : assert_cnt;
  assign run_inc  = {1'b0, run_q} + RunOne;
  // One extra bit so threshold minus hysteresis cannot wrap near the negative limit.
  assign lo_th    = $signed({busy_th[W-1], busy_th}) - $signed({1'b0, {(W-4){1'b0}}, hyst});
  assign rssi_ext = $signed({rssi_half_db[W-1], rssi_half_db});
  assign above    = rssi_half_db_valid && (rssi_half_db >= busy_th);
  assign below    = rssi_half_db_valid && (rssi_ext < lo_th);
  assign peak_max = (rssi_half_db > peak_q) ? rssi_half_db : peak_q;

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    hold_d  = hold_q;
    peak_d  = peak_q;
    pub_d   = pub_q;
    brise_d = 1'b0;
    irise_d = 1'b0;

    if (rssi_half_db_valid && (state_q == StBusy || state_q == StHold)) begin
      peak_d = peak_max;
    end

    if (tx_on) begin
      state_d = StBusy;
      run_d   = '0;
      if (state_q == StIdle || state_q == StPend) begin
        brise_d = 1'b1;
        peak_d  = RssiMin;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (above) begin
            if (eff_cnt == CntOne) begin
              state_d = StBusy;
              brise_d = 1'b1;
              peak_d  = rssi_half_db;
            end else begin
              state_d = StPend;
              run_d   = CntOne;
            end
          end
        end
        StPend: begin
          if (above) begin
            if (run_inc >= {1'b0, eff_cnt}) begin
              state_d = StBusy;
              brise_d = 1'b1;
              peak_d  = rssi_half_db;
              run_d   = '0;
            end else begin
              run_d = run_inc[CNT_WIDTH-1:0];
            end
          end else if (rssi_half_db_valid) begin
            state_d = StIdle;
            run_d   = '0;
          end
        end
        StBusy: begin
          // tx_q high here means tx_on just fell.
          if (tx_q || below) begin
            state_d = StHold;
            hold_d  = hold_cycles;
          end
        end
        StHold: begin
          if (above) begin
            state_d = StBusy;
          end else if (hold_q == '0) begin
            state_d = StIdle;
            irise_d = 1'b1;
            pub_d   = peak_d;
          end else begin
            hold_d = hold_q - HoldOne;
          end
        end
        default: ;
      endcase
    end

    idle_d = (state_d == StIdle) || (state_d == StPend);

    if (busy_time_clr) begin
      bt_d = '0;
    end else if (!idle_q && !(&bt_q)) begin
      bt_d = bt_q + BtOne;
    end else begin
      bt_d = bt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      run_q   <= '0;
      hold_q  <= '0;
      peak_q  <= RssiMin;
      pub_q   <= RssiMin;
      bt_q    <= '0;
      idle_q  <= 1'b1;
      brise_q <= 1'b0;
      irise_q <= 1'b0;
      tx_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      hold_q  <= hold_d;
      peak_q  <= peak_d;
      pub_q   <= pub_d;
      bt_q    <= bt_d;
      idle_q  <= idle_d;
      brise_q <= brise_d;
      irise_q <= irise_d;
      tx_q    <= tx_on;
    end
  end

  assign ch_idle           = idle_q;
  assign ch_busy_rise      = brise_q;
  assign ch_idle_rise      = irise_q;
  assign busy_time         = bt_q;
  assign rssi_peak_half_db = pub_q;
  assign state             = state_q;

endmodule
